csi2tx_csr_access_arbiter: RTL

Shares the single CSR local bus of the register interface between two requesters: requester 0 is the AHB slave local-bus port, and requester 1 is the internal configuration sequencer that loads trim, DFE and PLL defaults after reset. The block sits between those two masters and the register interface. It grants one access at a time with round-robin fairness, drives one read or write strobe per access, waits for `ready`, and returns the read data and completion to the owner. An optional watchdog aborts accesses that never receive `ready`.

---
 rtl/csi2tx_csr_arb_pkg.sv | 18 +
 rtl/csi2tx_csr_arb_rr_pick.sv | 20 ++
 rtl/csi2tx_csr_access_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/csi2tx_csr_arb_pkg.sv
// Shared types and constants for the CSI-2 TX CSR local-bus access arbiter.
package csi2tx_csr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } arb_state_t;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned REQ_AHB = 0;
  localparam int unsigned REQ_CFG = 1;

  // Read data returned when an access is aborted by the watchdog
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/csi2tx_csr_arb_rr_pick.sv
// Combinational two-way round-robin picker: on a tie the requester that did not own the last access wins.
module csi2tx_csr_arb_rr_pick
  import csi2tx_csr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_owner,
  output logic [NUM_REQ-1:0] winner_c,
  output logic               valid_c
);

  always_comb begin
    winner_c = req;
    if (req[REQ_AHB] && req[REQ_CFG]) begin
      winner_c = last_owner ? 2'b01 : 2'b10;
    end
  end

  assign valid_c = |req;

endmodule

// File: rtl/csi2tx_csr_access_arbiter.sv
// Arbitrates the CSR local bus between the AHB slave port and the config sequencer.
// Optional ready watchdog enabled by defining CSI2TX_CSR_ARB_TIMEOUT_EN.
module csi2tx_csr_access_arbiter
  import csi2tx_csr_arb_pkg::*;
#(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic               clk_sys,
  input  logic               clk_sys_rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_wr,
  input  logic [AW-1:0]      req_addr0,
  input  logic [AW-1:0]      req_addr1,
  input  logic [DW-1:0]      req_wdata0,
  input  logic [DW-1:0]      req_wdata1,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] err,
  output logic [DW-1:0]      rdata,
  output logic               csr_cs_n,
  output logic               csr_rd,
  output logic               csr_wr,
  output logic [AW-1:0]      csr_addr,
  output logic [DW-1:0]      csr_wr_data,
  input  logic [DW-1:0]      csr_rd_data,
  input  logic               ready
);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  arb_state_t         state, state_d;
  logic               last_owner, last_owner_d;
  logic               owner, owner_d;
  logic               wr_q, wr_d;
  logic [NUM_REQ-1:0] gnt_d, done_d, err_d;
  logic [DW-1:0]      rdata_d;
  logic               csr_cs_n_d, csr_rd_d, csr_wr_d;
  logic [AW-1:0]      csr_addr_d;
  logic [DW-1:0]      csr_wr_data_d;

  logic [NUM_REQ-1:0] pick_c;
  logic               pick_valid_c;
  logic               sel_cfg, sel_wr;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_wdata;
  logic [NUM_REQ-1:0] owner_oh;

  csi2tx_csr_arb_rr_pick u_pick (
    .req        (req),
    .last_owner (last_owner),
    .winner_c   (pick_c),
    .valid_c    (pick_valid_c)
  );

  assign sel_cfg   = pick_c[REQ_CFG];
  assign sel_wr    = sel_cfg ? req_wr[REQ_CFG] : req_wr[REQ_AHB];
  assign sel_addr  = sel_cfg ? req_addr1 : req_addr0;
  assign sel_wdata = sel_cfg ? req_wdata1 : req_wdata0;
  assign owner_oh  = owner ? 2'b10 : 2'b01;

`ifdef CSI2TX_CSR_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt, cnt_d, cnt_inc;

  assign cnt_inc = cnt + CW'(1);

  // Watchdog cycle counter for the WAIT state
  always_ff @(posedge clk_sys or negedge clk_sys_rst_n) begin
    if (!clk_sys_rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_d;
    end
  end
`endif

  // State and registered outputs
  always_ff @(posedge clk_sys or negedge clk_sys_rst_n) begin
    if (!clk_sys_rst_n) begin
      state       <= IDLE;
      last_owner  <= 1'b1;
      owner       <= 1'b0;
      wr_q        <= 1'b0;
      gnt         <= '0;
      done        <= '0;
      err         <= '0;
      rdata       <= '0;
      csr_cs_n    <= 1'b1;
      csr_rd      <= 1'b0;
      csr_wr      <= 1'b0;
      csr_addr    <= '0;
      csr_wr_data <= '0;
    end else begin
      state       <= state_d;
      last_owner  <= last_owner_d;
      owner       <= owner_d;
      wr_q        <= wr_d;
      gnt         <= gnt_d;
      done        <= done_d;
      err         <= err_d;
      rdata       <= rdata_d;
      csr_cs_n    <= csr_cs_n_d;
      csr_rd      <= csr_rd_d;
      csr_wr      <= csr_wr_d;
      csr_addr    <= csr_addr_d;
      csr_wr_data <= csr_wr_data_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state;
    last_owner_d  = last_owner;
    owner_d       = owner;
    wr_d          = wr_q;
    gnt_d         = gnt;
    done_d        = '0;
    err_d         = '0;
    rdata_d       = rdata;
    csr_cs_n_d    = csr_cs_n;
    csr_rd_d      = 1'b0;
    csr_wr_d      = 1'b0;
    csr_addr_d    = csr_addr;
    csr_wr_data_d = csr_wr_data;
`ifdef CSI2TX_CSR_ARB_TIMEOUT_EN
    cnt_d         = cnt;
`endif

    case (state)
      IDLE: begin
        if (pick_valid_c) begin
          owner_d       = sel_cfg;
          wr_d          = sel_wr;
          gnt_d         = pick_c;
          csr_addr_d    = sel_addr;
          csr_wr_data_d = sel_wdata;
          csr_cs_n_d    = 1'b0;
          csr_rd_d      = !sel_wr;
          csr_wr_d      = sel_wr;
          state_d       = ISSUE;
        end
      end

      ISSUE: begin
`ifdef CSI2TX_CSR_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = WAIT;
      end

      WAIT: begin
`ifdef CSI2TX_CSR_ARB_TIMEOUT_EN
        cnt_d = cnt_inc;
`endif
        if (ready) begin
          if (!wr_q) begin
            rdata_d = csr_rd_data;
          end
          done_d  = owner_oh;
          state_d = DONE;
        end
`ifdef CSI2TX_CSR_ARB_TIMEOUT_EN
        else if (cnt_inc == TO_LAST) begin
          if (!wr_q) begin
            rdata_d = DW'(TIMEOUT_RDATA);
          end
          done_d  = owner_oh;
          err_d   = owner_oh;
          state_d = DONE;
        end
`endif
      end

      DONE: begin
        last_owner_d = owner;
        gnt_d        = '0;
        csr_cs_n_d   = 1'b1;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
